// File: rtl/idecoder_queue_pkg.sv
// Packages for the RV32I decode queue: ISA constants, decoded-entry types and the decode function.
// Defining IDECODER_QUEUE_ILLEGAL_EN adds a per-entry illegal-instruction flag to dec_instr_t.
package rvi_pkg;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
endpackage

package copperv_pkg;
  // Must equal the PC_WIDTH used by the queue instances.
  localparam int PC_W = 32;

  typedef enum logic [3:0] {
    LUI        = 4'd0,
    AUIPC      = 4'd1,
    JAL        = 4'd2,
    JALR       = 4'd3,
    RESERVED_4 = 4'd4,
    BRANCH     = 4'd5,
    LOAD       = 4'd6,
    STORE      = 4'd7,
    OP_IMM     = 4'd8,
    OP         = 4'd9
  } opcode_e;

  typedef struct packed {
    opcode_e         opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [9:0]      funct;
    logic [PC_W-1:0] pc;
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    logic            illegal;
`endif
  } dec_instr_t;
endpackage

package idecoder_queue_pkg;
  import rvi_pkg::*;
  import copperv_pkg::*;

  function automatic dec_instr_t decode_instr(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    dec_instr_t  d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        shift;
    logic [31:0] imm_i;
    f3    = instr[14:12];
    f7    = instr[31:25];
    shift = (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SRL_SRA);
    imm_i = {{20{instr[31]}}, instr[31:20]};
    d        = '0;
    d.opcode = RESERVED_4;
    d.pc     = pc;
    case (instr[6:0])
      OPCODE_OP: begin
        d.opcode = OP;
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        d.funct  = {f7, f3};
      end
      OPCODE_OP_IMM: begin
        d.opcode = OP_IMM;
        d.rs1    = instr[19:15];
        d.rd     = instr[11:7];
        // Shift-immediates carry shamt in the imm field and funct3 ahead of funct7.
        if (shift) begin
          d.imm   = {27'b0, instr[24:20]};
          d.funct = {f3, f7};
        end else begin
          d.imm   = imm_i;
          d.funct = {7'b0, f3};
        end
      end
      OPCODE_JALR, OPCODE_LOAD: begin
        d.opcode = (instr[6:0] == OPCODE_JALR) ? JALR : LOAD;
        d.rs1    = instr[19:15];
        d.rd     = instr[11:7];
        d.imm    = imm_i;
        d.funct  = {7'b0, f3};
      end
      OPCODE_STORE: begin
        d.opcode = STORE;
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.imm    = {{20{instr[31]}}, f7, instr[11:7]};
        d.funct  = {7'b0, f3};
      end
      OPCODE_BRANCH: begin
        d.opcode = BRANCH;
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        d.funct  = {7'b0, f3};
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        d.opcode = (instr[6:0] == OPCODE_LUI) ? LUI : AUIPC;
        d.rd     = instr[11:7];
        d.imm    = {instr[31:12], 12'b0};
      end
      OPCODE_JAL: begin
        d.opcode = JAL;
        d.rd     = instr[11:7];
        d.imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    d.illegal = (instr[1:0] != 2'b11) || (d.opcode == RESERVED_4)
             || ((instr[6:0] == OPCODE_OP) && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT))
             || ((instr[6:0] == OPCODE_OP_IMM) && (f3 == FUNCT3_SLL) && (f7 != FUNCT7_BASE))
             || ((instr[6:0] == OPCODE_OP_IMM) && (f3 == FUNCT3_SRL_SRA)
                 && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT));
`endif
    return d;
  endfunction
endpackage

// File: rtl/idecoder_queue_if.sv
// Fetch-side and execute-side handshakes of the decode queue; slave is the queue's view.
// With IDECODER_QUEUE_ILLEGAL_EN the dec_illegal signal is added.
interface idecoder_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
);
  import copperv_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                instr_valid;
  logic                instr_ready;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                dec_valid;
  logic                dec_ready;
  opcode_e             dec_opcode;
  logic [4:0]          dec_rs1;
  logic [4:0]          dec_rs2;
  logic [4:0]          dec_rd;
  logic [31:0]         dec_imm;
  logic [9:0]          dec_funct;
  logic [PC_WIDTH-1:0] dec_pc;
  logic [CNT_W-1:0]    count;
`ifdef IDECODER_QUEUE_ILLEGAL_EN
  logic                dec_illegal;
`endif

  modport slave (
    input  instr_valid, instr, instr_pc, dec_ready,
    output instr_ready, dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd,
           dec_imm, dec_funct, dec_pc, count
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    , output dec_illegal
`endif
  );

  modport master (
    output instr_valid, instr, instr_pc, dec_ready,
    input  instr_ready, dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd,
           dec_imm, dec_funct, dec_pc, count
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    , input dec_illegal
`endif
  );
endinterface

// File: rtl/idecoder_fifo.sv
// Synchronous FIFO of decoded entries with flush; flush wins over push and pop.
// Push while full is accepted only when a pop happens in the same cycle.
module idecoder_fifo
  import copperv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  dec_instr_t           wdata,
  output dec_instr_t           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  dec_instr_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !flush && (cnt != '0);
  assign do_push = push && !flush && ((cnt < CNT_FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
endmodule

// File: rtl/idecoder_queue.sv
// RV32I decode stage: decodes accepted words, queues them and presents the head downstream.
// IDECODER_QUEUE_ILLEGAL_EN adds dec_illegal to the downstream interface.
module idecoder_queue
  import copperv_pkg::*;
  import idecoder_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  idecoder_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  dec_instr_t       wr_entry;
  dec_instr_t       head;
  dec_instr_t       head_out;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // A full queue still accepts when the head leaves in the same cycle.
  assign bus.instr_ready = !flush && ((cnt < CNT_W'(DEPTH)) || bus.dec_ready);
  assign bus.dec_valid   = (cnt != '0);
  assign push            = bus.instr_valid && bus.instr_ready;
  assign pop             = bus.dec_valid && bus.dec_ready;

  assign wr_entry = decode_instr(bus.instr, PC_W'(bus.instr_pc));

  idecoder_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (cnt)
  );

  always_comb begin
    head_out        = '0;
    head_out.opcode = RESERVED_4;
    if (bus.dec_valid) head_out = head;
  end

  assign bus.dec_opcode = head_out.opcode;
  assign bus.dec_rs1    = head_out.rs1;
  assign bus.dec_rs2    = head_out.rs2;
  assign bus.dec_rd     = head_out.rd;
  assign bus.dec_imm    = head_out.imm;
  assign bus.dec_funct  = head_out.funct;
  assign bus.dec_pc     = PC_WIDTH'(head_out.pc);
  assign bus.count      = cnt;
`ifdef IDECODER_QUEUE_ILLEGAL_EN
  assign bus.dec_illegal = head_out.illegal;
`endif
endmodule

// File: tb/tb_idecoder_queue.sv
// Self-checking bench for idecoder_queue: directed decode/fill/flush/reset cases plus
// randomized traffic against a queue-based reference model.
module tb_idecoder_queue;
  import copperv_pkg::*;

  localparam int DEPTH    = 4;
  localparam int PC_WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  idecoder_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) bus ();

  idecoder_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DW     [4] = '{32'hFFF10093, 32'h40525193, 32'h407302B3, 32'h008000EF};
  localparam opcode_e     D_OPC  [4] = '{OP_IMM, OP_IMM, OP, JAL};
  localparam logic [4:0]  D_RD   [4] = '{5'd1, 5'd3, 5'd5, 5'd1};
  localparam logic [4:0]  D_RS1  [4] = '{5'd2, 5'd4, 5'd6, 5'd0};
  localparam logic [4:0]  D_RS2  [4] = '{5'd0, 5'd0, 5'd7, 5'd0};
  localparam logic [31:0] D_IMM  [4] = '{32'hFFFFFFFF, 32'd5, 32'd0, 32'd8};
  localparam logic [9:0]  D_FUN  [4] = '{10'd0, 10'b1010100000, 10'h100, 10'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.instr_valid = v;
    bus.instr       = w;
    bus.instr_pc    = pc;
    bus.dec_ready   = rdy;
    flush           = fl;
  endtask

  // Reference decode: fields by instruction format, immediates from weighted bits.
  function automatic dec_instr_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_instr_t e;
    int         v;
    int         f3;
    int         f7;
    bit         known;
    e = '0;
    e.opcode = RESERVED_4;
    e.pc = pc;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    known = 1'b1;
    case (w[6:0])
      7'h33: begin
        e.opcode = OP; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.funct = 10'(f7 * 8 + f3);
      end
      7'h13, 7'h67, 7'h03: begin
        e.opcode = (w[6:0] == 7'h13) ? OP_IMM : ((w[6:0] == 7'h67) ? JALR : LOAD);
        e.rd = w[11:7]; e.rs1 = w[19:15];
        if (w[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
          e.imm = 32'(int'(w[24:20]));
          e.funct = 10'(f3 * 128 + f7);
        end else begin
          v = int'(w[30:20]);
          if (w[31]) v = v - 2048;
          e.imm = 32'(v);
          e.funct = 10'(f3);
        end
      end
      7'h23: begin
        e.opcode = STORE; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        v = int'(w[30:25]) * 32 + int'(w[11:7]);
        if (w[31]) v = v - 2048;
        e.imm = 32'(v); e.funct = 10'(f3);
      end
      7'h63: begin
        e.opcode = BRANCH; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) v = v - 4096;
        e.imm = 32'(v); e.funct = 10'(f3);
      end
      7'h37, 7'h17: begin
        e.opcode = (w[6:0] == 7'h37) ? LUI : AUIPC; e.rd = w[11:7];
        e.imm = w & 32'hFFFFF000;
      end
      7'h6F: begin
        e.opcode = JAL; e.rd = w[11:7];
        v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) v = v - 1048576;
        e.imm = 32'(v);
      end
      default: known = 1'b0;
    endcase
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    e.illegal = !known || (w[1:0] != 2'b11)
             || (w[6:0] == 7'h33 && f7 != 0 && f7 != 32)
             || (w[6:0] == 7'h13 && f3 == 1 && f7 != 0)
             || (w[6:0] == 7'h13 && f3 == 5 && f7 != 0 && f7 != 32);
`endif
    return e;
  endfunction

  function automatic dec_instr_t observed();
    dec_instr_t o;
    o = '0;
    o.opcode = bus.dec_opcode;
    o.rs1    = bus.dec_rs1;
    o.rs2    = bus.dec_rs2;
    o.rd     = bus.dec_rd;
    o.imm    = bus.dec_imm;
    o.funct  = bus.dec_funct;
    o.pc     = bus.dec_pc;
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    o.illegal = bus.dec_illegal;
`endif
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%0d dec_valid=%b, required 0 and 0", bus.count, bus.dec_valid);
    end
    checks++;
    if (bus.dec_opcode !== RESERVED_4 || bus.dec_imm !== 32'd0 || bus.dec_pc !== 32'd0
        || bus.dec_rd !== 5'd0 || bus.dec_funct !== 10'd0) begin
      failures++;
      $display("FAIL reset_fields: opcode=%0d imm=%h pc=%h, required RESERVED_4 and zeros",
               bus.dec_opcode, bus.dec_imm, bus.dec_pc);
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: instr_ready=%b, required 1", bus.instr_ready);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW[i], 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_opcode !== D_OPC[i] || bus.dec_rd !== D_RD[i]
          || bus.dec_rs1 !== D_RS1[i] || bus.dec_rs2 !== D_RS2[i] || bus.dec_imm !== D_IMM[i]
          || bus.dec_funct !== D_FUN[i] || bus.dec_pc !== 32'h1000 + 32'(i * 4)) begin
        failures++;
        $display("FAIL decode_%0d: got v=%b opc=%0d rd=%0d rs1=%0d rs2=%0d imm=%h funct=%h pc=%h, required opc=%0d rd=%0d rs1=%0d rs2=%0d imm=%h funct=%h",
                 i, bus.dec_valid, bus.dec_opcode, bus.dec_rd, bus.dec_rs1, bus.dec_rs2,
                 bus.dec_imm, bus.dec_funct, bus.dec_pc, D_OPC[i], D_RD[i], D_RS1[i],
                 D_RS2[i], D_IMM[i], D_FUN[i]);
      end
      tick();
    end
    checks++;
    if (bus.count !== 3'd0) begin
      failures++;
      $display("FAIL decode_drain: count=%0d, required 0", bus.count);
    end
  endtask

  task automatic test_fill();
    logic [31:0] fw [5];
    for (int k = 0; k < 5; k++) fw[k] = (32'(k + 10) << 20) | (32'(k + 1) << 7) | 32'h13;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, fw[k], 32'h200 + 32'(k * 4), 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.instr_ready !== (k < 4)) begin
        failures++;
        $display("FAIL fill_ready_%0d: instr_ready=%b, required %b", k, bus.instr_ready, (k < 4));
      end
      tick();
    end
    checks++;
    if (bus.count !== 3'd4 || bus.instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: count=%0d instr_ready=%b, required 4 and 0", bus.count, bus.instr_ready);
    end
    bus.dec_ready = 1'b1;
    #1;
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready_on_pop: instr_ready=%b, required 1", bus.instr_ready);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bus.dec_pc !== 32'h200 + 32'(j * 4) || bus.dec_imm !== 32'(j + 10)
          || bus.dec_rd !== 5'(j + 1)) begin
        failures++;
        $display("FAIL fill_order_%0d: pc=%h imm=%0d rd=%0d, required pc=%h imm=%0d rd=%0d",
                 j, bus.dec_pc, bus.dec_imm, bus.dec_rd, 32'h200 + 32'(j * 4), j + 10, j + 1);
      end
      tick();
      if (j == 0) begin
        bus.instr_valid = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd4) begin
          failures++;
          $display("FAIL fill_push_pop_full: count=%0d, required 4", bus.count);
        end
      end
    end
    checks++;
    if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain: count=%0d dec_valid=%b, required 0 and 0", bus.count, bus.dec_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h00100093, 32'h400 + 32'(k * 4), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (bus.count !== 3'd3) begin
      failures++;
      $display("FAIL flush_prefill: count=%0d, required 3", bus.count);
    end
    drive(1'b1, 32'h7FF00093, 32'hBAD0, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: instr_ready=%b, required 0", bus.instr_ready);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0 || bus.dec_opcode !== RESERVED_4) begin
      failures++;
      $display("FAIL flush_empty: count=%0d dec_valid=%b opcode=%0d, required 0 0 RESERVED_4",
               bus.count, bus.dec_valid, bus.dec_opcode);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.dec_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_output_%0d: dec_valid=%b pc=%h, required 0", k, bus.dec_valid, bus.dec_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h00200113, 32'h500 + 32'(k * 4), 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (bus.count !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_prefill: count=%0d, required 2", bus.count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.dec_valid !== 1'b0 || bus.dec_opcode !== RESERVED_4) begin
      failures++;
      $display("FAIL rstmid_empty: count=%0d dec_valid=%b opcode=%0d, required 0 0 RESERVED_4",
               bus.count, bus.dec_valid, bus.dec_opcode);
    end
    drive(1'b1, 32'h12345037, 32'h600, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.dec_valid !== 1'b1 || bus.dec_opcode !== LUI || bus.dec_imm !== 32'h12345000
        || bus.dec_rd !== 5'd0 || bus.dec_pc !== 32'h600) begin
      failures++;
      $display("FAIL rstmid_push: v=%b opc=%0d imm=%h pc=%h, required 1 LUI 12345000 600",
               bus.dec_valid, bus.dec_opcode, bus.dec_imm, bus.dec_pc);
    end
    tick();
  endtask

`ifdef IDECODER_QUEUE_ILLEGAL_EN
  task automatic test_illegal();
    logic [31:0] iw [3];
    logic        ie [3];
    iw = '{32'h00000000, 32'hC0525193, 32'h00000013};
    ie = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, iw[i], 32'h700, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.dec_valid !== 1'b1 || bus.dec_illegal !== ie[i]) begin
        failures++;
        $display("FAIL illegal_%0d: dec_valid=%b dec_illegal=%b, required 1 and %b",
                 i, bus.dec_valid, bus.dec_illegal, ie[i]);
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    dec_instr_t  exp_q [$];
    dec_instr_t  obs;
    logic [6:0]  opcs [9];
    logic [31:0] w;
    logic [31:0] pc;
    logic        v, rdy, fl, exp_ready;
    int          sel;
    opcs = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    for (int n = 0; n < 600; n++) begin
      w   = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 9) w[6:0] = opcs[sel];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      pc  = $urandom & 32'hFFFFFFFC;
      v   = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 5);
      drive(v, w, pc, rdy, fl);
      #1;
      exp_ready = !fl && ((exp_q.size() < DEPTH) || rdy);
      checks++;
      if (bus.instr_ready !== exp_ready || bus.dec_valid !== (exp_q.size() != 0)
          || bus.count !== 3'(exp_q.size())) begin
        failures++;
        $display("FAIL rand_ctrl_%0d: ready=%b valid=%b count=%0d, required %b %b %0d",
                 n, bus.instr_ready, bus.dec_valid, bus.count, exp_ready,
                 (exp_q.size() != 0), exp_q.size());
      end
      obs = observed();
      checks++;
      if (exp_q.size() != 0) begin
        if (obs !== exp_q[0]) begin
          failures++;
          $display("FAIL rand_head_%0d: got %h, required %h", n, obs, exp_q[0]);
        end
      end else if (obs.opcode !== RESERVED_4 || obs.imm !== 32'd0 || obs.pc !== 32'd0) begin
        failures++;
        $display("FAIL rand_empty_%0d: got %h, required RESERVED_4 with zero fields", n, obs);
      end
      if (fl) begin
        exp_q.delete();
      end else begin
        if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (v && exp_ready) exp_q.push_back(model_decode(w, pc));
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_decode();
    test_fill();
    test_flush();
    test_reset_mid();
`ifdef IDECODER_QUEUE_ILLEGAL_EN
    test_illegal();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
